// File: rtl/addsub_pkg.sv
// Shared encodings for the adder/subtractor operand sweep sequencer.
package addsub_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] RUN_ADD = 2'd1;
  localparam logic [STATE_W-1:0] RUN_SUB = 2'd2;
  localparam logic [STATE_W-1:0] DONE    = 2'd3;

  localparam logic CTRL_ADD = 1'b0;
  localparam logic CTRL_SUB = 1'b1;

endpackage

// File: rtl/addsub_ref_model.sv
// Combinational golden model of the 4-bit adder/subtractor (subtract is a + ~b + 1).
module addsub_ref_model
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic [WIDTH-1:0] exp_sum_c,
  output logic             exp_cout_c
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [SUM_W-1:0] total;

  always_comb begin
    total = '0;
    if (ctrl == CTRL_SUB) begin
      total = {1'b0, a} + {1'b0, ~b} + SUM_W'(1);
    end else begin
      total = {1'b0, a} + {1'b0, b};
    end
  end

  assign exp_sum_c  = total[WIDTH-1:0];
  assign exp_cout_c = total[WIDTH];

endmodule

// File: rtl/addsub_sweep_ctrl.sv
// Sweeps every (a,b) pair in add then subtract mode, sampling the adder at the end of each hold window.
// Optional result checker enabled by defining ADDSUB_SWEEP_CHECK_EN.
module addsub_sweep_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               ctrl,
  input  logic [WIDTH-1:0]   sum,
  input  logic               cout,
  output logic               sample,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   err_cnt,
  output logic               err_flag
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned ERR_W  = 2 * WIDTH + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0]  OPND_MAX  = '1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]   a_d, b_d;
  logic               ctrl_d, sample_d, busy_d, done_d;
  logic               hold_last;

  assign hold_last = (hold_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      a       <= '0;
      b       <= '0;
      ctrl    <= CTRL_ADD;
      sample  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      a       <= a_d;
      b       <= b_d;
      ctrl    <= ctrl_d;
      sample  <= sample_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and registered-output logic; b steps fastest, a carries on b wrap.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    a_d      = a;
    b_d      = b;
    ctrl_d   = ctrl;
    sample_d = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN_ADD;
          hold_d  = '0;
          a_d     = '0;
          b_d     = '0;
          ctrl_d  = CTRL_ADD;
          busy_d  = 1'b1;
        end
      end
      RUN_ADD, RUN_SUB: begin
        if (hold_last) begin
          hold_d = '0;
          b_d    = b + WIDTH'(1);
          if (b == OPND_MAX) begin
            a_d = a + WIDTH'(1);
          end
          if ((a == OPND_MAX) && (b == OPND_MAX)) begin
            if (state_q == RUN_ADD) begin
              state_d = RUN_SUB;
              ctrl_d  = CTRL_SUB;
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end else begin
          hold_d   = hold_q + HOLD_W'(1);
          sample_d = (hold_d == HOLD_LAST);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef ADDSUB_SWEEP_CHECK_EN
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             mismatch;
  logic             sweep_start;
  logic [ERR_W-1:0] err_cnt_d;
  logic             err_flag_d;

  addsub_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a          (a),
    .b          (b),
    .ctrl       (ctrl),
    .exp_sum_c  (exp_sum),
    .exp_cout_c (exp_cout)
  );

  // Compare in the sample cycle; the count updates on the capturing edge.
  always_comb begin
    sweep_start = (state_q == IDLE) && start;
    mismatch    = busy && hold_last && ((sum != exp_sum) || (cout != exp_cout));
    err_cnt_d   = err_cnt;
    err_flag_d  = err_flag;
    if (sweep_start) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt != ERR_MAX) begin
        err_cnt_d = err_cnt + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      err_cnt  <= err_cnt_d;
      err_flag <= err_flag_d;
    end
  end
`else
  logic unused_adder_result;
  assign unused_adder_result = ^{sum, cout};
  assign err_cnt  = '0;
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_sweep_ctrl.sv
// Directed-plus-random bench for addsub_sweep_ctrl with a behavioural adder and sweep model.
`timescale 1ns/1ps
module tb_addsub_sweep_ctrl;

  localparam int unsigned W       = 4;
  localparam int unsigned H       = 10;
  localparam int          PAIRS   = 1 << (2 * W);
  localparam int          TOT     = 2 * PAIRS * H;
  localparam int          ERR_MAX = (1 << (2 * W + 1)) - 1;
  localparam int          M       = (1 << W) - 1;
`ifdef ADDSUB_SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a, b, sum;
  logic         ctrl, cout, sample, busy, done, err_flag;
  logic [2*W:0] err_cnt;
  bit           fault = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_sweep_ctrl #(
    .WIDTH       (W),
    .HOLD_CYCLES (H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .ctrl     (ctrl),
    .sum      (sum),
    .cout     (cout),
    .sample   (sample),
    .busy     (busy),
    .done     (done),
    .err_cnt  (err_cnt),
    .err_flag (err_flag)
  );

  // Attached adder; the fault pins sum bit 0 low.
  always_comb begin
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    r  = ctrl ? (ia + (M - ib) + 1) : (ia + ib);
    sum  = W'(r & M);
    cout = (r > M);
    if (fault) sum[0] = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sweep from start; abort_e>=0 pulls reset after that edge, junk_e>=0 pulses start mid-run.
  task automatic run_sweep(input string nm, input bit flt, input int abort_e, input int junk_e);
    int seq_bad = 0, first_bad = -1, n_samp = 0, n_done = 0, done_e = -1, ctrl_rise = -1;
    int exp_err = 0;
    int k, j, kk, ia, ib, tsum, fsum;
    bit tc, ec, es;
    logic [W-1:0] ea, eb;
    fault = flt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= TOT + 1; e++) begin
      @(negedge clk);
      k = e / H; j = e % H; kk = k % PAIRS;
      ia = kk >> W; ib = kk & M;
      ec = (k >= PAIRS); es = (j == H - 1);
      ea = W'(ia); eb = W'(ib);
      if (e < TOT) begin
        if ({a, b, ctrl, sample, busy, done} !== {ea, eb, ec, es, 1'b1, 1'b0}) begin
          seq_bad++;
          if (first_bad < 0) first_bad = e;
        end
      end else if ({sample, busy, done} !== {1'b0, 1'b0, (e == TOT)}) begin
        seq_bad++;
        if (first_bad < 0) first_bad = e;
      end
      if (sample === 1'b1) n_samp++;
      if (done === 1'b1) begin n_done++; done_e = e; end
      if (ctrl === 1'b1 && ctrl_rise < 0) ctrl_rise = e;
      if (e == 0) begin
        check({nm, "_entry_err_cnt"}, 64'(err_cnt), 64'(0));
        check({nm, "_entry_err_flag"}, 64'(err_flag), 64'(0));
      end
      if (e == abort_e) begin
        check({nm, "_seq_before_abort"}, 64'(seq_bad), 64'(0));
        check({nm, "_err_before_abort"}, 64'(err_cnt), 64'(CHK ? exp_err : 0));
        #2 rst_n = 1'b0;
        #1 check({nm, "_async_reset"}, 64'({a, b, ctrl, sample, busy, done, err_cnt, err_flag}), 64'(0));
        repeat (2) @(negedge clk);
        check({nm, "_held_reset"}, 64'({a, b, ctrl, sample, busy, done, err_cnt, err_flag}), 64'(0));
        start = 1'b0;
        rst_n = 1'b1;
        return;
      end
      if (es && e < TOT) begin
        if (ec) begin tsum = (ia - ib) & M; tc = (ia >= ib); end
        else begin tsum = (ia + ib) & M; tc = ((ia + ib) > M); end
        fsum = flt ? (tsum & ~1) : tsum;
        if (fsum != tsum || tc != tc) exp_err++;
      end
      start = (e + 1 == junk_e) || (e + 1 == TOT + 1);
      @(posedge clk);
    end
    start = 1'b0;
    check($sformatf("%s_seq_first_bad_edge_%0d", nm, first_bad), 64'(seq_bad), 64'(0));
    check({nm, "_sample_count"}, 64'(n_samp), 64'(2 * PAIRS));
    check({nm, "_done_pulses"}, 64'(n_done), 64'(1));
    check({nm, "_done_edge"}, 64'(done_e), 64'(TOT));
    check({nm, "_ctrl_rise_edge"}, 64'(ctrl_rise), 64'(PAIRS * H));
    check({nm, "_err_cnt"}, 64'(err_cnt), 64'(CHK ? ((exp_err > ERR_MAX) ? ERR_MAX : exp_err) : 0));
    check({nm, "_err_flag"}, 64'(err_flag), 64'(CHK && exp_err > 0));
    @(negedge clk);
    check({nm, "_idle_after_done"}, 64'({busy, done, sample}), 64'(0));
  endtask

  initial begin
    // Reset held with start asserted: outputs at reset values, no sweep begins.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({a, b, ctrl, sample, busy, done, err_cnt, err_flag}), 64'(0));
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 64'({busy, done, sample, a, b}), 64'(0));

    repeat ($urandom_range(1, 5)) @(negedge clk);
    run_sweep("clean", 1'b0, -1, 50 * H + int'($urandom_range(0, H - 1)));

    repeat ($urandom_range(1, 5)) @(negedge clk);
    run_sweep("fault", 1'b1, -1, (PAIRS + int'($urandom_range(0, PAIRS - 1))) * H);

    repeat ($urandom_range(1, 5)) @(negedge clk);
    run_sweep("abort", 1'b1, 100 * H + int'($urandom_range(0, H - 1)), -1);

    repeat ($urandom_range(1, 5)) @(negedge clk);
    run_sweep("restart", 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
